// File: rtl/dcm_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcm_reset_sequencer_pkg
// Brief  : Sequencer state encodings, status-field widths and a sizing helper.
// Rev    : 1.0  initial release
// ============================================================================
package dcm_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_t;

    localparam int unsigned c_retry_w = 4;
    localparam int unsigned c_loss_w  = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcm_reset_sequencer_lock_sync.sv
`default_nettype none
// ============================================================================
// Module : dcm_reset_sequencer_lock_sync
// Brief  : WIDTH-bit two-flop synchronizer for the asynchronous DCM LOCKED lines.
// Rev    : 1.0  initial release
// ============================================================================
module dcm_reset_sequencer_lock_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/dcm_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dcm_reset_sequencer
// Brief  : Releases chained DCM resets in index order as upstream DCMs lock,
//          then system reset after a settle period; restarts on any lock loss.
//          Optional lock-loss counter enabled by defining LOCK_LOSS_COUNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module dcm_reset_sequencer
    import dcm_reset_sequencer_pkg::*;
#(
    parameter int unsigned N_DCM         = 3,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                 BOARD_CLOCK,
    input  logic                 RST_N,
    input  logic [N_DCM-1:0]     DCM_LOCKED,
    output logic [N_DCM-1:0]     DCM_RST,
    output logic                 SYS_RST_N,
    output logic                 CLOCKS_READY,
    output logic                 FAULT,
    output logic [c_retry_w-1:0] RETRY_COUNT
`ifdef LOCK_LOSS_COUNT_EN
    ,
    input  logic                 LOSS_CLR,
    output logic [c_loss_w-1:0]  LOSS_COUNT
`endif
);

    localparam int unsigned c_timer_w = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam int unsigned c_idx_w   = (N_DCM > 1) ? $clog2(N_DCM) : 1;

    localparam logic [c_timer_w-1:0] c_rst_last    = c_timer_w'(RST_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_lock_last   = c_timer_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_settle_last = c_timer_w'(SETTLE_CYCLES - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last    = c_idx_w'(N_DCM - 1);
    localparam logic [c_retry_w-1:0] c_retry_lim   = c_retry_w'(MAX_RETRIES);
    localparam logic [c_retry_w-1:0] c_retry_sat   = '1;

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_idx_w-1:0]     w_idx_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [c_timer_w-1:0]   w_timer_nxt;
    logic [c_retry_w-1:0]   r_retry;
    logic [c_retry_w-1:0]   w_retry_nxt;
    logic [c_retry_w-1:0]   w_retry_inc;
    logic [N_DCM-1:0]       r_dcm_rst;
    logic [N_DCM-1:0]       w_dcm_rst_nxt;
    logic                   r_sys_rst_n;
    logic                   r_ready;
    logic                   r_fault;
    logic [N_DCM-1:0]       w_lock;
    logic [N_DCM-1:0]       w_below;
    logic                   w_upstream_ok;
    logic                   w_all_locked;

    dcm_reset_sequencer_lock_sync #(
        .WIDTH (N_DCM)
    ) u_lock_sync (
        .clk     (BOARD_CLOCK),
        .rst_n   (RST_N),
        .i_async (DCM_LOCKED),
        .o_sync  (w_lock)
    );

    always_comb begin
        w_below = '0;
        for (int j = 0; j < N_DCM; j++) begin
            w_below[j] = (j < int'(r_idx));
        end
    end

    assign w_upstream_ok = &(w_lock | ~w_below);
    assign w_all_locked  = &w_lock;
    assign w_retry_inc   = (r_retry == c_retry_sat) ? r_retry : r_retry + c_retry_w'(1);

    // Upstream loss outranks a lock of the current DCM, which outranks its timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer + c_timer_w'(1);
        w_retry_nxt = r_retry;
        case (r_state)
            ST_ASSERT: begin
                w_idx_nxt = '0;
                if (r_timer == c_rst_last) begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (!w_upstream_ok) begin
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end else if (w_lock[r_idx]) begin
                    w_timer_nxt = '0;
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_w'(1);
                    end
                end else if (r_timer == c_lock_last) begin
                    w_timer_nxt = '0;
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = (w_retry_inc == c_retry_lim) ? ST_FAULT : ST_ASSERT;
                end
            end
            ST_SETTLE: begin
                if (!w_all_locked) begin
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end else if (r_timer == c_settle_last) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            ST_RUN: begin
                w_timer_nxt = r_timer;
                if (!w_all_locked) begin
                    w_state_nxt = ST_ASSERT;
                    w_timer_nxt = '0;
                end
            end
            ST_FAULT: begin
                w_timer_nxt = r_timer;
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so every reset line is glitch-free.
    always_comb begin
        w_dcm_rst_nxt = '1;
        for (int j = 0; j < N_DCM; j++) begin
            if (w_state_nxt == ST_WAIT) begin
                w_dcm_rst_nxt[j] = (j > int'(w_idx_nxt));
            end else if (w_state_nxt == ST_SETTLE || w_state_nxt == ST_RUN) begin
                w_dcm_rst_nxt[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge BOARD_CLOCK) begin
        if (!RST_N) begin
            r_state     <= ST_ASSERT;
            r_idx       <= '0;
            r_timer     <= '0;
            r_retry     <= '0;
            r_dcm_rst   <= '1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_timer     <= w_timer_nxt;
            r_retry     <= w_retry_nxt;
            r_dcm_rst   <= w_dcm_rst_nxt;
            r_sys_rst_n <= (w_state_nxt == ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign DCM_RST      = r_dcm_rst;
    assign SYS_RST_N    = r_sys_rst_n;
    assign CLOCKS_READY = r_ready;
    assign FAULT        = r_fault;
    assign RETRY_COUNT  = r_retry;

`ifdef LOCK_LOSS_COUNT_EN
    localparam logic [c_loss_w-1:0] c_loss_sat = '1;

    logic [c_loss_w-1:0] r_loss_cnt;
    logic                w_run_exit;

    assign w_run_exit = (r_state == ST_RUN) && (w_state_nxt == ST_ASSERT);

    // A clear coinciding with an increment leaves the counter at zero.
    always_ff @(posedge BOARD_CLOCK) begin
        if (!RST_N || LOSS_CLR) begin
            r_loss_cnt <= '0;
        end else if (w_run_exit && (r_loss_cnt != c_loss_sat)) begin
            r_loss_cnt <= r_loss_cnt + c_loss_w'(1);
        end
    end

    assign LOSS_COUNT = r_loss_cnt;
`endif

endmodule
`default_nettype wire
